// File: rtl/hd63701_timer.sv
// HD63701 on-chip timer: 16-bit free-running counter with output compare,
// input capture and overflow flags, mapped at internal registers $08-$0E.
module hd63701_timer #(
   parameter logic [15:0] FRC_PRESET  = 16'hFFF8,
   parameter logic [15:0] OCR_RESET   = 16'hFFFF,
   parameter int          SYNC_STAGES = 2
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       EN,
   input  logic       CS,
   input  logic       RW,
   input  logic [2:0] A,
   input  logic [7:0] DI,
   output logic [7:0] DO,
   input  logic       TIN,
   output logic       TOUT,
   output logic       IRQ2_TIM
);

   localparam logic [2:0] A_TCSR = 3'd0;
   localparam logic [2:0] A_FRCH = 3'd1;
   localparam logic [2:0] A_FRCL = 3'd2;
   localparam logic [2:0] A_OCRH = 3'd3;
   localparam logic [2:0] A_OCRL = 3'd4;
   localparam logic [2:0] A_ICRH = 3'd5;
   localparam logic [2:0] A_ICRL = 3'd6;

   logic [15:0]            frc, ocr, icr;
   logic [4:0]             ctl;            // EICI EOCI ETOI IEDG OLVL
   logic                   icf, ocf, tof;
   logic                   arm_icf, arm_ocf, arm_tof;
   logic [7:0]             rd_latch, wr_temp;
   logic [SYNC_STAGES-1:0] tin_sync;
   logic                   tin_prev, cmp_inhibit;

   logic rd, wr;
   logic rd_tcsr, rd_frch, rd_icrh;
   logic wr_tcsr, wr_frch, wr_frcl, wr_ocrh, wr_ocrl, wr_ocr;
   logic tin_s, cap_hit, cmp_hit, ovf_hit;
   logic icf_clr, ocf_clr, tof_clr;

   assign rd = EN & CS & RW;
   assign wr = EN & CS & ~RW;

   assign rd_tcsr = rd & (A == A_TCSR);
   assign rd_frch = rd & (A == A_FRCH);
   assign rd_icrh = rd & (A == A_ICRH);
   assign wr_tcsr = wr & (A == A_TCSR);
   assign wr_frch = wr & (A == A_FRCH);
   assign wr_frcl = wr & (A == A_FRCL);
   assign wr_ocrh = wr & (A == A_OCRH);
   assign wr_ocrl = wr & (A == A_OCRL);
   assign wr_ocr  = wr_ocrh | wr_ocrl;

   // Edge detector sits after the synchroniser; IEDG picks the polarity.
   assign tin_s   = tin_sync[SYNC_STAGES-1];
   assign cap_hit = EN & (ctl[1] ? (tin_s & ~tin_prev) : (~tin_s & tin_prev));
   assign cmp_hit = EN & ~cmp_inhibit & (frc == ocr);
   assign ovf_hit = EN & ~wr_frch & ~wr_frcl & (frc == 16'hFFFF);

   assign icf_clr = rd_icrh & arm_icf;
   assign ocf_clr = wr_ocr  & arm_ocf;
   assign tof_clr = rd_frch & arm_tof;

   assign IRQ2_TIM = (icf & ctl[4]) | (ocf & ctl[3]) | (tof & ctl[2]);

   // NOTE: state uses non-blocking assignments so every flop samples the
   // pre-edge values of the others, matching the hardware it describes.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         frc         <= 16'h0000;
         ocr         <= OCR_RESET;
         icr         <= 16'h0000;
         ctl         <= 5'b0;
         icf         <= 1'b0;
         ocf         <= 1'b0;
         tof         <= 1'b0;
         arm_icf     <= 1'b0;
         arm_ocf     <= 1'b0;
         arm_tof     <= 1'b0;
         rd_latch    <= 8'h00;
         wr_temp     <= 8'h00;
         tin_sync    <= '0;
         tin_prev    <= 1'b0;
         cmp_inhibit <= 1'b0;
         TOUT        <= 1'b0;
      end else if (EN) begin
         if (wr_frch) begin
            wr_temp <= DI;
            frc     <= FRC_PRESET;
         end else if (wr_frcl) begin
            frc <= {wr_temp, DI};
         end else begin
            frc <= frc + 16'd1;
         end

         if (rd_frch) rd_latch <= frc[7:0];
         if (wr_tcsr) ctl <= DI[4:0];
         if (wr_ocrh) ocr[15:8] <= DI;
         if (wr_ocrl) ocr[7:0]  <= DI;
         cmp_inhibit <= wr_ocr;

         tin_sync <= {tin_sync[SYNC_STAGES-2:0], TIN};
         tin_prev <= tin_s;
         if (cap_hit) icr <= frc;
         if (cmp_hit) TOUT <= ctl[0];

         // A set in the same cycle as a clear wins; the clear still disarms.
         icf <= cap_hit | (icf & ~icf_clr);
         ocf <= cmp_hit | (ocf & ~ocf_clr);
         tof <= ovf_hit | (tof & ~tof_clr);
         arm_icf <= ~icf_clr & (arm_icf | (rd_tcsr & icf));
         arm_ocf <= ~ocf_clr & (arm_ocf | (rd_tcsr & ocf));
         arm_tof <= ~tof_clr & (arm_tof | (rd_tcsr & tof));
      end
   end

   // NOTE: DO gets a default before the case so no path infers a latch.
   always_comb begin
      DO = 8'h00;
      case (A)
         A_TCSR:  DO = {icf, ocf, tof, ctl};
         A_FRCH:  DO = frc[15:8];
         A_FRCL:  DO = rd_latch;
         A_OCRH:  DO = ocr[15:8];
         A_OCRL:  DO = ocr[7:0];
         A_ICRH:  DO = icr[15:8];
         A_ICRL:  DO = icr[7:0];
         default: DO = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_hd63701_timer.sv
// Self-checking bench for hd63701_timer: bus reads and pin states are
// queued as expectations and popped when the DUT output is sampled.
module tb_hd63701_timer;

   logic       CLK, RST, EN, CS, RW, TIN;
   logic [2:0] A;
   logic [7:0] DI, DO;
   logic       TOUT, IRQ2_TIM;

   typedef struct {
      string      tag;
      logic [7:0] exp;
   } sb_entry_t;

   sb_entry_t sb_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   hd63701_timer dut (
      .CLK(CLK), .RST(RST), .EN(EN), .CS(CS), .RW(RW), .A(A), .DI(DI),
      .DO(DO), .TIN(TIN), .TOUT(TOUT), .IRQ2_TIM(IRQ2_TIM)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic score(input string tag, input logic [7:0] act);
      sb_entry_t e;
      e = sb_q.pop_front();
      check({tag, "/", e.tag}, act, e.exp);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         EN = 1'b1; CS = 1'b0;
         @(posedge CLK);
         #1 EN = 1'b0;
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      @(negedge CLK);
      EN = 1'b1; CS = 1'b1; RW = 1'b0; A = a; DI = d;
      @(posedge CLK);
      #1 EN = 1'b0; CS = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [2:0] a, input logic [7:0] exp);
      @(negedge CLK);
      EN = 1'b1; CS = 1'b1; RW = 1'b1; A = a;
      sb_q.push_back('{tag, exp});
      #1 score("rd", DO);
      @(posedge CLK);
      #1 EN = 1'b0; CS = 1'b0;
   endtask

   task automatic peek(input string tag, input logic [2:0] a, input logic [7:0] exp);
      A = a;
      sb_q.push_back('{tag, exp});
      #1 score("peek", DO);
   endtask

   task automatic pins(input string tag, input logic tout, input logic irq);
      sb_q.push_back('{tag, {6'b0, tout, irq}});
      score("pins", {6'b0, TOUT, IRQ2_TIM});
   endtask

   initial begin
      RST = 1'b1; EN = 1'b0; CS = 1'b0; RW = 1'b1; A = 3'd0; DI = 8'h00; TIN = 1'b0;
      #12 RST = 1'b0;

      // Reset values
      peek("rst_tcsr", 3'd0, 8'h00);
      peek("rst_frch", 3'd1, 8'h00);
      peek("rst_ocrh", 3'd3, 8'hFF);
      peek("rst_ocrl", 3'd4, 8'hFF);
      peek("rst_icrl", 3'd6, 8'h00);
      peek("rst_a7",   3'd7, 8'h00);
      pins("rst_pins", 1'b0, 1'b0);

      // Counting, with EN-low edges in between that must not advance
      idle(3);
      repeat (4) @(posedge CLK);
      #1;
      rd("frch_3", 3'd1, 8'h00);
      rd("frcl_3", 3'd2, 8'h03);

      // FRC writes
      wr(3'd1, 8'h12);
      wr(3'd2, 8'h34);
      idle(2);
      rd("frch_1236", 3'd1, 8'h12);
      rd("frcl_1236", 3'd2, 8'h36);
      wr(3'd1, 8'hAB);
      idle(1);
      rd("frch_preset", 3'd1, 8'hFF);
      rd("frcl_preset", 3'd2, 8'hF9);

      // Output compare at 0010 with OLVL=1, EOCI=1
      wr(3'd3, 8'h00);
      wr(3'd4, 8'h10);
      wr(3'd0, 8'h09);
      wr(3'd1, 8'h00);
      wr(3'd2, 8'h00);
      idle(16);
      pins("pre_cmp", 1'b0, 1'b0);
      idle(1);
      pins("cmp", 1'b1, 1'b1);
      peek("cmp_tcsr", 3'd0, 8'h49);
      rd("cmp_tcsr_arm", 3'd0, 8'h49);
      wr(3'd4, 8'h20);
      pins("ocf_clr", 1'b1, 1'b0);
      peek("ocf_clr_tcsr", 3'd0, 8'h09);

      // Overflow with ETOI
      wr(3'd0, 8'h04);
      wr(3'd1, 8'hFF);
      wr(3'd2, 8'hFE);
      idle(2);
      peek("tof_set", 3'd0, 8'h24);
      pins("tof_irq", 1'b1, 1'b1);
      rd("frch_unarmed", 3'd1, 8'h00);
      peek("tof_kept", 3'd0, 8'h24);
      rd("tof_tcsr_arm", 3'd0, 8'h24);
      rd("frch_armed", 3'd1, 8'h00);
      peek("tof_clr", 3'd0, 8'h04);
      pins("tof_clr", 1'b1, 1'b0);

      // Input capture on rising edge, FRC=0100 at the detector
      wr(3'd0, 8'h12);
      TIN = 1'b1;
      wr(3'd1, 8'h01);
      wr(3'd2, 8'h00);
      idle(1);
      peek("icrh_cap", 3'd5, 8'h01);
      peek("icrl_cap", 3'd6, 8'h00);
      peek("icf_set", 3'd0, 8'h92);
      pins("icf_irq", 1'b1, 1'b1);
      TIN = 1'b0;
      idle(4);
      peek("icrl_fall", 3'd6, 8'h00);
      peek("icrh_fall", 3'd5, 8'h01);
      rd("icf_tcsr_arm", 3'd0, 8'h92);
      rd("icrh_clr", 3'd5, 8'h01);
      peek("icf_clr", 3'd0, 8'h12);
      pins("icf_clr", 1'b1, 1'b0);

      // Compare coinciding with an armed OCRH write: set wins, arm drops
      wr(3'd3, 8'h01);
      wr(3'd0, 8'h08);
      wr(3'd1, 8'h01);
      wr(3'd2, 8'h1E);
      idle(3);
      peek("ocf2_set", 3'd0, 8'h48);
      pins("ocf2_olvl0", 1'b0, 1'b1);
      rd("ocf2_arm", 3'd0, 8'h48);
      wr(3'd1, 8'h01);
      wr(3'd2, 8'h20);
      wr(3'd3, 8'h05);
      peek("set_wins", 3'd0, 8'h48);
      wr(3'd4, 8'h00);
      peek("arm_dropped", 3'd0, 8'h48);
      peek("ocrh_new", 3'd3, 8'h05);
      pins("ocf2_pins", 1'b0, 1'b1);

      // Asynchronous reset mid-count
      idle(3);
      #2 RST = 1'b1;
      #1 pins("rst2_pins", 1'b0, 1'b0);
      peek("rst2_tcsr", 3'd0, 8'h00);
      peek("rst2_frch", 3'd1, 8'h00);
      peek("rst2_ocrh", 3'd3, 8'hFF);
      peek("rst2_icrh", 3'd5, 8'h00);
      RST = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
